// File: rtl/buffer_ctrl.sv
// ---------------------------------------------------------------------------
// buffer_ctrl
//   Sequencer for the strided output buffer of a conv layer.
//   FILL  : follows the raster position of the padded input stream feeding the
//           PE array and writes only window results that land on the stride grid.
//   DRAIN : reads the grid back in row-major order under downstream
//           back-pressure. out_valid follows re by one cycle, which is the
//           buffer's read latency.
//
// Ports
//   clk        in   1       clock, posedge
//   rst        in   1       asynchronous active-high reset
//   start      in   1       begin one layer pass (honoured only in IDLE)
//   in_valid   in   1       PE array result for the current raster pixel
//   in_ready   out  1       high only in FILL
//   out_ready  in   1       downstream can take one buffer word
//   addr_x     out  ADDR+2  buffer column coordinate, registered
//   addr_y     out  ADDR+2  buffer row coordinate, registered
//   we         out  1       buffer write enable, registered
//   re         out  1       buffer read enable, registered
//   out_valid  out  1       buffer read data valid (re delayed one cycle)
//   busy       out  1       state != IDLE
//   done       out  1       one-cycle pulse while in DONE
//   state_dbg  out  2       current FSM state (debug observation)
//
// Handshake: an input pixel is consumed on a rising edge where in_valid and
// in_ready are both high; a buffer read is issued on a rising edge in DRAIN
// where out_ready is high. Neither side may retract anything; a low valid or
// ready simply stalls the counters for that cycle.
// ---------------------------------------------------------------------------
module buffer_ctrl #(
  parameter int IFM_SIZE    = 9,
  parameter int KERNEL_SIZE = 4,
  parameter int STRIDE      = 2,
  parameter int PAD         = 2,
  localparam int ADDR       = $clog2(IFM_SIZE - KERNEL_SIZE + 2*PAD + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            out_ready,
  output logic [ADDR+1:0] addr_x,
  output logic [ADDR+1:0] addr_y,
  output logic            we,
  output logic            re,
  output logic            out_valid,
  output logic            busy,
  output logic            done,
  output logic [1:0]      state_dbg
);

  localparam int P   = IFM_SIZE + 2*PAD;
  localparam int OUT = (P - KERNEL_SIZE) / STRIDE + 1;
  localparam int W   = ADDR + 2;

  localparam logic [W-1:0] LAST_PIX = W'(P - 1);
  localparam logic [W-1:0] LAST_OUT = W'(OUT - 1);
  localparam logic [W-1:0] KM1      = W'(KERNEL_SIZE - 1);
  localparam logic [W-1:0] STR      = W'(STRIDE);
  localparam logic [W-1:0] ONE      = W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [W-1:0] x_cnt, y_cnt;   // raster position of the next input pixel
  logic [W-1:0] i_cnt, j_cnt;   // output grid row / column of the next read
  logic         rd_all;         // last grid read has been issued
  logic         on_grid;
  logic         last_pix;

  // A window ending at (x,y) is on the stride grid once the kernel fits
  // entirely; the subtraction is only meaningful behind the >= guard.
  always_comb begin
    on_grid = (x_cnt >= KM1) && (y_cnt >= KM1) &&
              (((x_cnt - KM1) % STR) == '0) &&
              (((y_cnt - KM1) % STR) == '0);
  end

  always_comb begin
    last_pix = (x_cnt == LAST_PIX) && (y_cnt == LAST_PIX);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next state. DRAIN is left one cycle after the last read issues so that
  // the last read's out_valid coincides with DONE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_FILL;
      S_FILL:  if (in_valid && last_pix) state_next = S_DRAIN;
      S_DRAIN: if (rd_all) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Counters and registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      rd_all    <= 1'b0;
      addr_x    <= '0;
      addr_y    <= '0;
      we        <= 1'b0;
      re        <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      we        <= 1'b0;
      re        <= 1'b0;
      out_valid <= re;
      done      <= (state_next == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            x_cnt  <= '0;
            y_cnt  <= '0;
            i_cnt  <= '0;
            j_cnt  <= '0;
            rd_all <= 1'b0;
          end
        end
        S_FILL: begin
          if (in_valid) begin
            addr_x <= x_cnt;
            addr_y <= y_cnt;
            we     <= on_grid;
            if (x_cnt == LAST_PIX) begin
              x_cnt <= '0;
              y_cnt <= y_cnt + ONE;
            end else begin
              x_cnt <= x_cnt + ONE;
            end
          end
        end
        S_DRAIN: begin
          if (out_ready && !rd_all) begin
            re     <= 1'b1;
            addr_x <= KM1 + STR * j_cnt;
            addr_y <= KM1 + STR * i_cnt;
            if (j_cnt == LAST_OUT) begin
              j_cnt <= '0;
              if (i_cnt == LAST_OUT) begin
                i_cnt  <= '0;
                rd_all <= 1'b1;
              end else begin
                i_cnt <= i_cnt + ONE;
              end
            end else begin
              j_cnt <= j_cnt + ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_FILL);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_buffer_ctrl
//   Self-checking bench for buffer_ctrl. Two instances: the default 9/4/2/2
//   configuration and a 6/3/1/0 configuration. The expected write and read
//   address lists are generated from the output-grid definition and queued
//   when a pass starts; a monitor on the falling edge pops and compares every
//   we / re strobe and tracks the expected in_ready / busy / out_valid / done.
// ---------------------------------------------------------------------------
module tb_buffer_ctrl;

  // Default configuration
  localparam int IFM = 9, K = 4, S = 2, PD = 2;
  localparam int P   = IFM + 2*PD;
  localparam int OUT = (P - K) / S + 1;
  localparam int W   = $clog2(IFM - K + 2*PD + 1) + 2;

  // Small stride-1 configuration
  localparam int IFM2 = 6, K2 = 3, S2 = 1, PD2 = 0;
  localparam int P2   = IFM2 + 2*PD2;
  localparam int OUT2 = (P2 - K2) / S2 + 1;
  localparam int W2   = $clog2(IFM2 - K2 + 2*PD2 + 1) + 2;

  // Pass length from start to the done pulse: one cycle to leave IDLE, one
  // per input pixel, one per grid read, one for the last read to issue.
  localparam int PASS_CYC = 1 + P*P + OUT*OUT + 1;

  logic clk = 1'b0;
  logic rst;

  logic         start, in_valid, out_ready;
  logic         in_ready, we, re, out_valid, busy, done;
  logic [W-1:0] addr_x, addr_y;
  logic [1:0]   state_dbg;

  logic          start2, in_valid2, out_ready2;
  logic          in_ready2, we2, re2, out_valid2, busy2, done2;
  logic [W2-1:0] addr_x2, addr_y2;
  logic [1:0]    state_dbg2;

  always #5 clk = ~clk;

  buffer_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .out_ready(out_ready), .addr_x(addr_x), .addr_y(addr_y), .we(we), .re(re),
    .out_valid(out_valid), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  buffer_ctrl #(.IFM_SIZE(IFM2), .KERNEL_SIZE(K2), .STRIDE(S2), .PAD(PD2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_ready(out_ready2), .addr_x(addr_x2), .addr_y(addr_y2), .we(we2), .re(re2),
    .out_valid(out_valid2), .busy(busy2), .done(done2), .state_dbg(state_dbg2)
  );

  // Scoreboard: expected {addr_x, addr_y} pairs, 8 bits each
  logic [15:0] wr_q[$], rd_q[$], wr2_q[$], rd2_q[$];

  int errors = 0;
  int checks = 0;
  int n_wr, n_rd, n_done, n_wr2, n_rd2, n_done2;

  // Monitor-side reference state
  logic fill_phase, busy_exp;
  logic p_start_idle, p_acc, p_rdy, p_re, p_done, p_re2;
  int   pix;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Grid results are written and read in row-major order of output positions.
  task automatic push_expect();
    for (int oy = 0; oy < OUT; oy++)
      for (int ox = 0; ox < OUT; ox++) begin
        wr_q.push_back({8'(K - 1 + S*ox), 8'(K - 1 + S*oy)});
        rd_q.push_back({8'(K - 1 + S*ox), 8'(K - 1 + S*oy)});
      end
  endtask

  task automatic push_expect2();
    for (int oy = 0; oy < OUT2; oy++)
      for (int ox = 0; ox < OUT2; ox++) begin
        wr2_q.push_back({8'(K2 - 1 + S2*ox), 8'(K2 - 1 + S2*oy)});
        rd2_q.push_back({8'(K2 - 1 + S2*ox), 8'(K2 - 1 + S2*oy)});
      end
  endtask

  // mode 0: continuous valid/ready; mode 1: toggling in_valid, random
  // out_ready; mode 2: continuous plus random start pulses while busy.
  // abort_rd > 0 returns as soon as that many reads have been seen.
  task automatic run_pass(input int mode, input int abort_rd, output int cyc);
    n_wr = 0; n_rd = 0; n_done = 0;
    push_expect();
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (done) break;
      if (cyc >= 3000) begin
        chk("pass_timeout_done", done, 1);
        break;
      end
      if (abort_rd > 0 && n_rd >= abort_rd) break;
      in_valid  = (mode == 1) ? ~in_valid : 1'b1;
      out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 2) start = ($urandom_range(0, 3) == 0);
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic end_checks();
    repeat (3) @(posedge clk);
    #1;
    chk("write_count", n_wr, OUT*OUT);
    chk("read_count", n_rd, OUT*OUT);
    chk("done_count", n_done, 1);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("busy_after_pass", busy, 0);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst) begin
        wr_q.delete(); rd_q.delete(); wr2_q.delete(); rd2_q.delete();
        fill_phase = 0; busy_exp = 0; pix = 0;
        p_start_idle = 0; p_acc = 0; p_rdy = 0; p_re = 0; p_done = 0; p_re2 = 0;
      end else begin
        // Advance the reference phase from last cycle's events
        if (p_done) busy_exp = 0;
        if (p_start_idle) begin
          fill_phase = 1; busy_exp = 1; pix = 0;
        end
        if (p_acc) begin
          pix++;
          if (pix == P*P) fill_phase = 0;
        end

        chk("in_ready", in_ready, fill_phase);
        chk("busy", busy, busy_exp);
        chk("out_valid_lat", out_valid, p_re);
        if (we || re) chk("we_re_exclusive", we & re, 0);
        if (we) begin
          n_wr++;
          chk("we_after_accept", p_acc, 1);
          if (wr_q.size() == 0) chk("wr_unexpected", we, 0);
          else chk("wr_addr", {8'(addr_x), 8'(addr_y)}, wr_q.pop_front());
        end
        if (re) begin
          n_rd++;
          chk("re_after_ready", p_rdy, 1);
          if (rd_q.size() == 0) chk("rd_unexpected", re, 0);
          else chk("rd_addr", {8'(addr_x), 8'(addr_y)}, rd_q.pop_front());
        end
        if (done) begin
          n_done++;
          chk("done_with_last_valid", out_valid, 1);
          chk("done_reads_drained", rd_q.size(), 0);
        end

        // Second instance
        chk("out_valid2_lat", out_valid2, p_re2);
        if (we2 || re2) chk("we2_re2_exclusive", we2 & re2, 0);
        if (we2) begin
          n_wr2++;
          if (wr2_q.size() == 0) chk("wr2_unexpected", we2, 0);
          else chk("wr2_addr", {8'(addr_x2), 8'(addr_y2)}, wr2_q.pop_front());
        end
        if (re2) begin
          n_rd2++;
          if (rd2_q.size() == 0) chk("rd2_unexpected", re2, 0);
          else chk("rd2_addr", {8'(addr_x2), 8'(addr_y2)}, rd2_q.pop_front());
        end
        if (done2) n_done2++;

        p_start_idle = start && !busy_exp;
        p_acc        = in_valid && fill_phase;
        p_rdy        = out_ready;
        p_re         = re;
        p_done       = done;
        p_re2        = re2;
      end
    end
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    start = 0; in_valid = 0; out_ready = 0;
    start2 = 0; in_valid2 = 0; out_ready2 = 0;
    n_wr = 0; n_rd = 0; n_done = 0; n_wr2 = 0; n_rd2 = 0; n_done2 = 0;

    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", we, 0);
    chk("rst_re", re, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_addr", {8'(addr_x), 8'(addr_y)}, 0);
    rst = 1'b0;

    // Continuous fill and drain
    run_pass(0, 0, cyc);
    chk("pass_cycles_cont", cyc, PASS_CYC);
    end_checks();

    // Stalled fill, random back-pressure in drain
    run_pass(1, 0, cyc);
    end_checks();

    // Start pulses while busy must not change anything
    run_pass(2, 0, cyc);
    chk("pass_cycles_restart", cyc, PASS_CYC);
    end_checks();

    // Asynchronous reset mid-drain after 10 reads
    run_pass(0, 10, cyc);
    chk("abort_reads_seen", n_rd, 10);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_we", we, 0);
    chk("mid_rst_re", re, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("no_done_after_abort", n_done, 0);
    run_pass(1, 0, cyc);
    end_checks();

    // Stride-1 configuration
    n_wr2 = 0; n_rd2 = 0; n_done2 = 0;
    push_expect2();
    @(posedge clk); #1;
    start2 = 1'b1; in_valid2 = 1'b1;
    cyc = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      start2 = 1'b0;
      if (done2) break;
      if (cyc >= 3000) begin
        chk("pass2_timeout_done", done2, 1);
        break;
      end
      out_ready2 = 1'($urandom_range(0, 1));
    end
    in_valid2 = 1'b0; out_ready2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("write2_count", n_wr2, OUT2*OUT2);
    chk("read2_count", n_rd2, OUT2*OUT2);
    chk("done2_count", n_done2, 1);
    chk("wr2_q_empty", wr2_q.size(), 0);
    chk("rd2_q_empty", rd2_q.size(), 0);
    chk("busy2_after_pass", busy2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
